// File: rtl/tile_draw_scheduler.sv
// tile_draw_scheduler: arbitrates per-lane tile draw requests (round-robin) and
// an optional lane-line clear request between a block-draw engine and a
// line-draw engine, running one job at a time with a one-cycle DONE handshake.
// Optional feature: define TILE_DRAW_LINE_CLEAR_EN to enable the line-clear path;
// without it the line inputs are ignored and line_go/line_ack are tied low.
module tile_draw_scheduler #(
    parameter logic [2:0] BLOCK_COLOUR = 3'b111,
    parameter logic [2:0] LINE_COLOUR  = 3'b000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [3:0]  req,
    input  logic [23:0] lane_offset,
    input  logic        line_req,
    input  logic [2:0]  line_lane,
    input  logic        block_done,
    input  logic        line_done,
    output logic        block_go,
    output logic        line_go,
    output logic [2:0]  line_id,
    output logic [5:0]  offset,
    output logic [3:0]  ack,
    output logic        line_ack,
    output logic        busy,
    output logic        plot,
    output logic [2:0]  colour
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        BLOCK_RUN = 2'd1,
        LINE_RUN  = 2'd2,
        DONE      = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  rrPtr_q, rrPtr_d;
    logic        lastLine_q, lastLine_d;
    logic [1:0]  grantLane_q, grantLane_d;
    logic [2:0]  lineId_q, lineId_d;
    logic [5:0]  offset_q, offset_d;

    logic        lineReqEn;
    logic        lineDoneEn;
    logic [2:0]  lineLaneIn;

`ifdef TILE_DRAW_LINE_CLEAR_EN
    assign lineReqEn  = line_req;
    assign lineDoneEn = line_done;
    assign lineLaneIn = line_lane;
`else
    logic unusedLineInputs;
    assign lineReqEn        = 1'b0;
    assign lineDoneEn       = 1'b0;
    assign lineLaneIn       = 3'b010;
    assign unusedLineInputs = ^{line_req, line_lane, line_done};
`endif

    logic [5:0] laneOff [4];
    logic       blockFound;
    logic [1:0] blockWinner;
    logic [1:0] searchIdx;
    logic [2:0] lineLaneFix;

    // Unpack lane offsets and find the first requesting lane at or after the RR pointer
    always_comb begin
        blockFound  = 1'b0;
        blockWinner = rrPtr_q;
        searchIdx   = rrPtr_q;
        for (int i = 0; i < 4; i++) begin
            laneOff[i] = lane_offset[6*i +: 6];
        end
        for (int i = 0; i < 4; i++) begin
            searchIdx = rrPtr_q + 2'(i);
            if (!blockFound && req[searchIdx]) begin
                blockFound  = 1'b1;
                blockWinner = searchIdx;
            end
        end
    end

    // State and job-context registers; context is captured only when leaving IDLE
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            rrPtr_q     <= 2'd0;
            lastLine_q  <= 1'b0;
            grantLane_q <= 2'd0;
            lineId_q    <= 3'b001;
            offset_q    <= 6'd0;
        end else begin
            state_q     <= state_d;
            rrPtr_q     <= rrPtr_d;
            lastLine_q  <= lastLine_d;
            grantLane_q <= grantLane_d;
            lineId_q    <= lineId_d;
            offset_q    <= offset_d;
        end
    end

    // Next-state: arbitrate in IDLE (line first unless it just ran and blocks wait)
    always_comb begin
        state_d     = state_q;
        rrPtr_d     = rrPtr_q;
        lastLine_d  = lastLine_q;
        grantLane_d = grantLane_q;
        lineId_d    = lineId_q;
        offset_d    = offset_q;
        lineLaneFix = ((lineLaneIn != 3'd0) && (lineLaneIn <= 3'd4)) ? lineLaneIn : 3'b010;
        case (state_q)
            IDLE: begin
                if (lineReqEn && !(lastLine_q && (|req))) begin
                    state_d    = LINE_RUN;
                    lastLine_d = 1'b1;
                    lineId_d   = lineLaneFix;
                    offset_d   = laneOff[lineLaneFix[1:0] - 2'd1];
                end else if (blockFound) begin
                    state_d     = BLOCK_RUN;
                    lastLine_d  = 1'b0;
                    grantLane_d = blockWinner;
                    lineId_d    = {1'b0, blockWinner} + 3'd1;
                    offset_d    = laneOff[blockWinner];
                    rrPtr_d     = blockWinner + 2'd1;
                end
            end
            BLOCK_RUN: begin
                if (block_done) begin
                    state_d = DONE;
                end
            end
            LINE_RUN: begin
                if (lineDoneEn) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs decoded from the current state and latched job context
    always_comb begin
        block_go = 1'b0;
        line_go  = 1'b0;
        ack      = 4'b0000;
        line_ack = 1'b0;
        busy     = (state_q != IDLE);
        plot     = 1'b0;
        colour   = 3'b000;
        case (state_q)
            BLOCK_RUN: begin
                block_go = 1'b1;
                plot     = !block_done;
                colour   = BLOCK_COLOUR;
            end
            LINE_RUN: begin
`ifdef TILE_DRAW_LINE_CLEAR_EN
                line_go  = 1'b1;
                plot     = !lineDoneEn;
                colour   = LINE_COLOUR;
`endif
            end
            DONE: begin
                if (lastLine_q) begin
`ifdef TILE_DRAW_LINE_CLEAR_EN
                    line_ack = 1'b1;
`endif
                end else begin
                    ack = 4'b0001 << grantLane_q;
                end
            end
            default: begin
                busy = (state_q != IDLE);
            end
        endcase
    end

    assign line_id = lineId_q;
    assign offset  = offset_q;

endmodule

// File: tb/tb_tile_draw_scheduler.sv
// tb_tile_draw_scheduler: randomized and directed jobs for tile_draw_scheduler,
// checked against a job-level reference model of the arbitration rules.
// Follows the TILE_DRAW_LINE_CLEAR_EN build option of the design.
module tb_tile_draw_scheduler;

    localparam logic [2:0] BLOCK_COLOUR = 3'b111;
    localparam logic [2:0] LINE_COLOUR  = 3'b000;
`ifdef TILE_DRAW_LINE_CLEAR_EN
    localparam bit LINE_EN = 1'b1;
`else
    localparam bit LINE_EN = 1'b0;
`endif

    logic        clock;
    logic        reset;
    logic [3:0]  req;
    logic [23:0] lane_offset;
    logic        line_req;
    logic [2:0]  line_lane;
    logic        block_done;
    logic        line_done;
    logic        block_go;
    logic        line_go;
    logic [2:0]  line_id;
    logic [5:0]  offset;
    logic [3:0]  ack;
    logic        line_ack;
    logic        busy;
    logic        plot;
    logic [2:0]  colour;

    int checkCount = 0;
    int passCount  = 0;

    // Reference model state: next lane to search from (1..4), last grant was a line
    int mNext     = 1;
    bit mLastLine = 1'b0;

    tile_draw_scheduler #(
        .BLOCK_COLOUR(BLOCK_COLOUR),
        .LINE_COLOUR (LINE_COLOUR)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .req        (req),
        .lane_offset(lane_offset),
        .line_req   (line_req),
        .line_lane  (line_lane),
        .block_done (block_done),
        .line_done  (line_done),
        .block_go   (block_go),
        .line_go    (line_go),
        .line_id    (line_id),
        .offset     (offset),
        .ack        (ack),
        .line_ack   (line_ack),
        .busy       (busy),
        .plot       (plot),
        .colour     (colour)
    );

    // Free-running clock, period 10
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, observed, expected, $time);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic applyStimulus(input logic [3:0] r, input logic lr, input logic [2:0] ll, input logic [23:0] offs);
        req         = r;
        line_req    = lr;
        line_lane   = ll;
        lane_offset = offs;
        block_done  = 1'b0;
        line_done   = 1'b0;
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "Outs"}, {14'd0, block_go, line_go, ack, line_ack, busy, plot, colour, offset}, 32'd0);
        checkOutput({tag, "Id"}, {29'd0, line_id}, 32'd1);
    endtask

    task automatic doReset();
        reset = 1'b1;
        applyStimulus(4'b0000, 1'b0, 3'd0, 24'd0);
        step();
        reset = 1'b0;
        mNext     = 1;
        mLastLine = 1'b0;
        checkResetState("reset");
    endtask

    // Model decision: kind 0 = nothing, 1 = block, 2 = line; lane is 1..4
    task automatic modelDecide(input logic [3:0] r, input logic lr, input logic [2:0] ll,
                               output int kind, output int lane);
        kind = 0;
        lane = 0;
        if (LINE_EN && lr && !(mLastLine && r != 4'd0)) begin
            kind = 2;
            lane = (ll >= 3'd1 && ll <= 3'd4) ? int'(ll) : 2;
        end else begin
            for (int k = 0; k < 4; k++) begin
                int cand;
                cand = ((mNext - 1 + k) % 4) + 1;
                if (kind == 0 && r[cand-1]) begin
                    kind = 1;
                    lane = cand;
                end
            end
        end
    endtask

    // One job from IDLE: grant, optional mid-job disturbance/reset, completion, DONE, IDLE
    task automatic runJob(input logic [3:0] r, input logic lr, input logic [2:0] ll, input logic [23:0] offs,
                          input int runCycles, input bit scramble, input int resetAt);
        int kind;
        int lane;
        logic [5:0] expOff;
        logic [2:0] expId;
        modelDecide(r, lr, ll, kind, lane);
        applyStimulus(r, lr, ll, offs);
        step();
        if (kind == 0) begin
            checkOutput("idleBusy", {31'd0, busy}, 32'd0);
            checkOutput("idleGo", {30'd0, block_go, line_go}, 32'd0);
            return;
        end
        expId  = 3'(lane);
        expOff = 6'((offs >> (6 * (lane - 1))) & 24'h3f);
        if (kind == 1) begin
            mNext     = (lane % 4) + 1;
            mLastLine = 1'b0;
        end else begin
            mLastLine = 1'b1;
        end
        checkOutput("grantBusy", {31'd0, busy}, 32'd1);
        checkOutput("grantGo", {30'd0, block_go, line_go}, (kind == 1) ? 32'd2 : 32'd1);
        checkOutput("grantId", {29'd0, line_id}, {29'd0, expId});
        if (kind == 1) checkOutput("grantOff", {26'd0, offset}, {26'd0, expOff});
        checkOutput("grantPlot", {31'd0, plot}, 32'd1);
        checkOutput("grantColour", {29'd0, colour}, (kind == 1) ? {29'd0, BLOCK_COLOUR} : {29'd0, LINE_COLOUR});
        for (int c = 0; c < runCycles; c++) begin
            if (c == resetAt) begin
                reset = 1'b1;
                step();
                reset = 1'b0;
                mNext     = 1;
                mLastLine = 1'b0;
                checkResetState("midReset");
                applyStimulus(4'b0000, 1'b0, 3'd0, 24'd0);
                return;
            end
            if (scramble) begin
                req         = 4'($urandom);
                lane_offset = 24'($urandom);
                line_lane   = 3'($urandom);
                line_req    = 1'($urandom);
            end
            if (kind == 1) line_done = 1'($urandom);
            else block_done = 1'($urandom);
            step();
            checkOutput("runGo", {30'd0, block_go, line_go}, (kind == 1) ? 32'd2 : 32'd1);
            checkOutput("runId", {29'd0, line_id}, {29'd0, expId});
            if (kind == 1) checkOutput("runOff", {26'd0, offset}, {26'd0, expOff});
        end
        if (kind == 1) begin
            block_done = 1'b1;
            line_done  = 1'b0;
        end else begin
            line_done  = 1'b1;
            block_done = 1'b0;
        end
        #1;
        checkOutput("donePlot", {31'd0, plot}, 32'd0);
        step();
        checkOutput("doneGo", {30'd0, block_go, line_go}, 32'd0);
        checkOutput("doneBusy", {31'd0, busy}, 32'd1);
        checkOutput("doneAck", {28'd0, ack}, (kind == 1) ? (32'd1 << (lane - 1)) : 32'd0);
        checkOutput("doneLineAck", {31'd0, line_ack}, (kind == 2) ? 32'd1 : 32'd0);
        checkOutput("doneColour", {28'd0, plot, colour}, 32'd0);
        req        = 4'b0000;
        line_req   = 1'b0;
        block_done = 1'($urandom);
        line_done  = 1'($urandom);
        step();
        checkOutput("idleAfterBusy", {31'd0, busy}, 32'd0);
        checkOutput("idleAfterAck", {27'd0, ack, line_ack}, 32'd0);
        checkOutput("idleAfterGo", {30'd0, block_go, line_go}, 32'd0);
    endtask

    // Directed scenarios followed by a randomized job stream
    initial begin
        reset = 1'b1;
        applyStimulus(4'b0000, 1'b0, 3'd0, 24'd0);
        step();
        step();
        reset = 1'b0;
        checkResetState("powerOn");
        mNext     = 1;
        mLastLine = 1'b0;

        $display("[TB] single lane 3 job with 20-cycle draw");
        runJob(4'b0100, 1'b0, 3'd0, {6'd9, 6'd5, 6'd7, 6'd3}, 19, 1'b0, -1);

        $display("[TB] all lanes requesting, round-robin order");
        doReset();
        for (int j = 0; j < 5; j++) begin
            runJob(4'b1111, 1'b0, 3'd0, 24'($urandom), j, 1'b0, -1);
        end

        $display("[TB] withdrawal and offset change mid-job");
        runJob(4'b0010, 1'b0, 3'd0, 24'($urandom), 6, 1'b1, -1);

        $display("[TB] reset in BLOCK_RUN then lane 4 alone");
        runJob(4'b0001, 1'b0, 3'd0, 24'($urandom), 6, 1'b0, 3);
        runJob(4'b1000, 1'b0, 3'd0, 24'($urandom), 2, 1'b0, -1);

        $display("[TB] stray done inputs while idle");
        block_done = 1'b1;
        line_done  = 1'b1;
        step();
        checkOutput("strayDoneBusy", {31'd0, busy}, 32'd0);
        block_done = 1'b0;
        line_done  = 1'b0;

`ifdef TILE_DRAW_LINE_CLEAR_EN
        $display("[TB] line vs block contention alternates");
        doReset();
        runJob(4'b0001, 1'b1, 3'd4, 24'($urandom), 2, 1'b0, -1);
        runJob(4'b0001, 1'b1, 3'd4, 24'($urandom), 2, 1'b0, -1);
        runJob(4'b0000, 1'b1, 3'd7, 24'($urandom), 1, 1'b0, -1);
`else
        $display("[TB] line request ignored for 50 cycles");
        applyStimulus(4'b0000, 1'b1, 3'd3, 24'($urandom));
        for (int c = 0; c < 50; c++) begin
            line_done = 1'($urandom);
            step();
            checkOutput("lineOffGo", {31'd0, line_go}, 32'd0);
            checkOutput("lineOffBusy", {31'd0, busy}, 32'd0);
        end
        line_req = 1'b0;
`endif

        $display("[TB] randomized jobs");
        for (int j = 0; j < 80; j++) begin
            logic [3:0] r;
            r = ($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom);
            runJob(r, 1'($urandom), 3'($urandom), 24'($urandom), int'($urandom_range(0, 6)),
                   1'($urandom), ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 3)) : -1);
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/tile_draw_scheduler.md
TILE_DRAW_SCHEDULER -- requirements
Module: tile_draw_scheduler

Interface
REQ-001 Parameter BLOCK_COLOUR, default 3'b111, colour driven while a tile block is drawn.
REQ-002 Parameter LINE_COLOUR, default 3'b000, colour driven while a lane line is cleared.
REQ-003 clock  input  1  single system clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 req  input  4  per-lane tile draw request; bit k = lane k+1, level-sensitive.
REQ-006 lane_offset  input  24  packed 6-bit offsets; bits [6k+5:6k] belong to lane k+1.
REQ-007 line_req  input  1  lane-line clear request, level-sensitive.
REQ-008 line_lane  input  3  lane id for line clear, 1..4.
REQ-009 block_done  input  1  completion flag from the block-draw engine.
REQ-010 line_done  input  1  completion flag from the line-draw engine.
REQ-011 block_go  output  1  run enable to the block-draw engine.
REQ-012 line_go  output  1  run enable to the line-draw engine.
REQ-013 line_id  output  3  lane id to the engine in service, 1..4.
REQ-014 offset  output  6  latched offset of the granted lane.
REQ-015 ack  output  4  one-hot, one-cycle pulse on completion of lane k+1 tile draw.
REQ-016 line_ack  output  1  one-cycle pulse on completion of a line clear.
REQ-017 busy  output  1  high in any state other than IDLE.
REQ-018 plot  output  1  pixel write enable to the VGA adapter.
REQ-019 colour  output  3  pixel colour to the VGA adapter.

Function
REQ-020 FSM states: IDLE, BLOCK_RUN, LINE_RUN, DONE; encoding free.
REQ-021 IDLE: arbitrate on the sampled inputs; a winner moves to BLOCK_RUN or LINE_RUN on the next edge, with line_id/offset latched on that same edge.
REQ-022 Latency: request high at edge N, so block_go or line_go is high from cycle N+1.
REQ-023 Block arbitration: round-robin over req[3:0], starting from the lane after the last granted one; after reset the search starts at lane 1.
REQ-024 Line vs block: line_req wins, unless the previous grant was a line and any req bit is high, in which case the block wins (strict alternation under contention).
REQ-025 line_lane outside 1..4 is forwarded as 3'b010 (lane 2).
REQ-026 BLOCK_RUN: block_go=1 and line_go=0, held until block_done=1 is sampled, then go to DONE.
REQ-027 LINE_RUN: line_go=1 and block_go=0, held until line_done=1 is sampled, then go to DONE.
REQ-028 DONE lasts exactly one cycle: both go signals 0; ack bit of the served lane or line_ack =1; then return to IDLE.
REQ-029 Gap: at least one cycle with both go low between consecutive jobs, so each engine re-initialises its coordinates.
REQ-030 line_id, offset and line_lane are frozen for the whole job; changes to req or lane_offset mid-job are ignored.
REQ-031 Withdrawal of the granted request mid-job does not abort the job; the draw completes and is acked.
REQ-032 block_go and line_go are never high in the same cycle.
REQ-033 plot = (BLOCK_RUN & !block_done) | (LINE_RUN & !line_done); colour = BLOCK_COLOUR in BLOCK_RUN, LINE_COLOUR in LINE_RUN, 3'b000 otherwise.
REQ-034 A done input arriving outside its RUN state is ignored.

Reset
REQ-035 reset=1 at an edge forces IDLE, with all outputs 0 on the next cycle: block_go, line_go, ack, line_ack, busy, plot, colour, offset; line_id = 3'b001.
REQ-036 reset mid-job abandons the job without an ack; the round-robin pointer returns to lane 1 and the last-grant flag is cleared.

Configuration
REQ-037 Macro TILE_DRAW_LINE_CLEAR_EN defined: line path present as specified.
REQ-038 Macro undefined: line_req, line_lane and line_done are ignored; line_go and line_ack are tied 0; LINE_RUN is unreachable; arbitration is round-robin over blocks only.

Verification
REQ-039 Reset, then req=4'b0100 with lane 3 offset=6'd5 -> block_go at N+1, line_id=3, offset=5; block_done after 20 cycles -> ack=4'b0100 for 1 cycle, busy low after.
REQ-040 req=4'b1111 held, block_done pulsed per job -> grants in lane order 1,2,3,4,1 with a 1-cycle go-low gap between jobs.
REQ-041 line_req=1, line_lane=4, req=4'b0001 together -> LINE_RUN with line_id=4 first; the next job is lane 1 even with line_req still high.
REQ-042 req[1] dropped and lane_offset changed mid-BLOCK_RUN -> line_id and offset stay fixed; ack=4'b0010 still issued.
REQ-043 reset asserted in BLOCK_RUN -> all outputs 0 next cycle, no ack; a later req=4'b1000 is still served (lane 4 is the only request).
REQ-044 Macro undefined: line_req=1 alone for 50 cycles -> line_go stays 0, busy stays 0.
